// File: rtl/rsa_rfid_pkg.sv
// rsa_rfid_pkg: definitions shared by the RSA reply path toward the RFID
// backscatter modulator.
//   CRC16_POLY / CRC16_INIT : EPC-style CRC-16 (x^16 + x^12 + x^5 + 1),
//                             non-reflected, preset to all ones.
//   framer_state_e          : reply framer FSM states.
//   crc16_step()            : advance the CRC register by one message bit.
package rsa_rfid_pkg;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2
   } framer_state_e;

   function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                              input logic        din);
      logic fb;
      fb = crc[15] ^ din;
      return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/reply_fifo.sv
// reply_fifo: word FIFO between RSA completion and the reply serializer.
// Parameters: WordSize (word width), FifoDepth (entries, power of two >= 2).
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   push, din       write din at the tail (caller guarantees space, or a
//                   simultaneous pop when full)
//   pop, dout       dout is the head word, combinational; pop advances it
//   full, empty     occupancy flags
//   count           occupancy, $clog2(FifoDepth)+1 bits
module reply_fifo #(
   parameter int WordSize  = 8,
   parameter int FifoDepth = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WordSize-1:0]        din,
   output logic [WordSize-1:0]        dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(FifoDepth):0] count
);

   localparam int AddrW = $clog2(FifoDepth);
   localparam int CntW  = AddrW + 1;

   logic [WordSize-1:0] mem_q [FifoDepth];
   logic [AddrW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]     count_q, count_d;

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == CntW'(FifoDepth));
   assign empty = (count_q == '0);
   assign count = count_q;

   // Pointers wrap naturally because FifoDepth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset. When full with a simultaneous pop, the write
   // lands in the slot being read out on the same edge, which is safe
   // because the popped word is captured by the reader on that edge.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/rsa_reply_framer.sv
// rsa_reply_framer: buffers RSA ciphertext words (one per done pulse) and,
// once FrameWords words are queued, serializes them MSB-first onto a
// bit-level valid/ready link toward the RFID backscatter modulator.
// Optional feature macro: RSA_REPLY_CRC16_EN appends the ones' complement of
// an EPC CRC-16 (poly 0x1021, init 0xFFFF) computed over the data bits.
// Parameters: WordSize, FrameWords (1..FifoDepth), FifoDepth (power of 2).
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   in_word, in_valid   ciphertext word and its done pulse
//   in_ready            FIFO not full
//   tx_bit, tx_valid    serial bit and qualifier toward the modulator
//   tx_ready            modulator accepts the presented bit
//   tx_last             high while presenting the final bit of a frame
//   busy                framer not idle
//   overflow            sticky: a word arrived while the FIFO was full
module rsa_reply_framer
   import rsa_rfid_pkg::*;
#(
   parameter int WordSize   = 8,
   parameter int FrameWords = 4,
   parameter int FifoDepth  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WordSize-1:0] in_word,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                tx_bit,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                tx_last,
   output logic                busy,
   output logic                overflow
);

   localparam int CntW = $clog2(FifoDepth) + 1;
   localparam int BitW = (WordSize > 1) ? $clog2(WordSize) : 1;
   localparam logic [BitW-1:0] BIT_LAST  = BitW'(WordSize - 1);
   localparam logic [CntW-1:0] FRAME_CNT = CntW'(FrameWords);
   localparam logic [CntW-1:0] WORD_LAST = CntW'(FrameWords - 1);

   framer_state_e       state_q, state_d;
   logic [WordSize-1:0] shift_q, shift_d;
   logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [CntW-1:0]     word_cnt_q, word_cnt_d;
   logic                overflow_q, overflow_d;
   logic                tx_valid_q, tx_valid_d;
   logic                tx_bit_q, tx_bit_d;
   logic                tx_last_q, tx_last_d;
`ifdef RSA_REPLY_CRC16_EN
   logic [15:0]         crc_q, crc_d;
   logic [3:0]          crc_cnt_q, crc_cnt_d;
`endif

   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [WordSize-1:0] fifo_dout;
   logic [CntW-1:0]     fifo_count;
   logic                hs;

   reply_fifo #(
      .WordSize  (WordSize),
      .FifoDepth (FifoDepth)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (in_word),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign in_ready = !fifo_full;
   // A full FIFO still takes a word on an edge where the framer pops one.
   assign fifo_push = in_valid && (!fifo_full || fifo_pop);

   assign tx_valid = tx_valid_q;
   assign tx_bit   = tx_bit_q;
   assign tx_last  = tx_last_q;
   assign busy     = (state_q != IDLE);
   assign overflow = overflow_q;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      fifo_pop   = 1'b0;
`ifdef RSA_REPLY_CRC16_EN
      crc_d      = crc_q;
      crc_cnt_d  = crc_cnt_q;
`endif
      hs         = tx_valid_q && tx_ready;

      unique case (state_q)
         IDLE: begin
            if ((fifo_count >= FRAME_CNT) && !fifo_empty) begin
               fifo_pop   = 1'b1;
               shift_d    = fifo_dout;
               bit_cnt_d  = BIT_LAST;
               word_cnt_d = WORD_LAST;
               state_d    = DATA;
            end
         end
         DATA: begin
            if (hs) begin
               shift_d = shift_q << 1;
`ifdef RSA_REPLY_CRC16_EN
               crc_d   = crc16_step(crc_q, shift_q[WordSize-1]);
`endif
               if (bit_cnt_q != '0) begin
                  bit_cnt_d = bit_cnt_q - 1'b1;
               end else if (word_cnt_q != '0) begin
                  // Next word loads on the same edge: no idle bit between words.
                  fifo_pop   = !fifo_empty;
                  shift_d    = fifo_dout;
                  bit_cnt_d  = BIT_LAST;
                  word_cnt_d = word_cnt_q - 1'b1;
               end else begin
`ifdef RSA_REPLY_CRC16_EN
                  state_d   = CRC;
                  crc_cnt_d = 4'd15;
`else
                  state_d   = IDLE;
`endif
               end
            end
         end
`ifdef RSA_REPLY_CRC16_EN
         CRC: begin
            if (hs) begin
               if (crc_cnt_q == '0) begin
                  state_d = IDLE;
                  crc_d   = CRC16_INIT;
               end else begin
                  crc_d     = crc_q << 1;
                  crc_cnt_d = crc_cnt_q - 1'b1;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      overflow_d = overflow_q || (in_valid && fifo_full && !fifo_pop);

      // Outputs are registered from the next-state values so they line up
      // with the state they describe.
      tx_valid_d = (state_d != IDLE);
      tx_bit_d   = 1'b0;
      if (state_d == DATA) tx_bit_d = shift_d[WordSize-1];
`ifdef RSA_REPLY_CRC16_EN
      if (state_d == CRC)  tx_bit_d = ~crc_d[15];
      tx_last_d  = (state_d == CRC) && (crc_cnt_d == '0);
`else
      tx_last_d  = (state_d == DATA) && (bit_cnt_d == '0) && (word_cnt_d == '0);
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         overflow_q <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_bit_q   <= 1'b0;
         tx_last_q  <= 1'b0;
`ifdef RSA_REPLY_CRC16_EN
         crc_q      <= CRC16_INIT;
         crc_cnt_q  <= '0;
`endif
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         overflow_q <= overflow_d;
         tx_valid_q <= tx_valid_d;
         tx_bit_q   <= tx_bit_d;
         tx_last_q  <= tx_last_d;
`ifdef RSA_REPLY_CRC16_EN
         crc_q      <= crc_d;
         crc_cnt_q  <= crc_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_rsa_reply_framer.sv
// tb_rsa_reply_framer: scoreboard bench for rsa_reply_framer (default
// parameters). Accepted words are grouped into frames by a reference model
// that expands them into the expected bit stream (plus CRC when
// RSA_REPLY_CRC16_EN is defined); a monitor pops and compares on every
// tx handshake.
`timescale 1ns/1ps
module tb_rsa_reply_framer;

   localparam int WordSize   = 8;
   localparam int FrameWords = 4;
   localparam int FifoDepth  = 8;
`ifdef RSA_REPLY_CRC16_EN
   localparam int CrcBits = 16;
`else
   localparam int CrcBits = 0;
`endif
   localparam int DataBits  = FrameWords * WordSize;
   localparam int FrameBits = DataBits + CrcBits;

   logic                clk = 1'b0;
   logic                reset;
   logic [WordSize-1:0] in_word;
   logic                in_valid;
   logic                in_ready;
   logic                tx_bit;
   logic                tx_valid;
   logic                tx_ready;
   logic                tx_last;
   logic                busy;
   logic                overflow;

   rsa_reply_framer #(
      .WordSize   (WordSize),
      .FrameWords (FrameWords),
      .FifoDepth  (FifoDepth)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_word  (in_word),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx_bit   (tx_bit),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_last  (tx_last),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic b;
      logic last;
      int   idx;
   } exp_bit_t;

   exp_bit_t            exp_q[$];
   logic [WordSize-1:0] pend_q[$];
   int checks   = 0;
   int failures = 0;
   int rdy_mode = 2;   // 0: tx_ready low, 1: high, 2: random

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s at %0t: bound expired", name, $time);
   endtask

   // Reference model: every FrameWords accepted words form one frame, sent
   // MSB-first, followed by ~CRC16 of the data bits when enabled.
   function automatic void model_accept(input logic [WordSize-1:0] w);
      logic        bits[$];
      logic [15:0] crc;
      pend_q.push_back(w);
      if (pend_q.size() == FrameWords) begin
         for (int i = 0; i < FrameWords; i++)
            for (int b = WordSize - 1; b >= 0; b--)
               bits.push_back(pend_q[i][b]);
`ifdef RSA_REPLY_CRC16_EN
         crc = 16'hFFFF;
         for (int i = 0; i < DataBits; i++)
            crc = {crc[14:0], 1'b0} ^ (((crc[15] ^ bits[i]) == 1'b1) ? 16'h1021 : 16'h0000);
         crc = ~crc;
         for (int b = 15; b >= 0; b--) bits.push_back(crc[b]);
`else
         crc = 16'h0000;
`endif
         for (int i = 0; i < bits.size(); i++)
            exp_q.push_back('{b: bits[i], last: (i == bits.size() - 1), idx: i});
         pend_q.delete();
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin : ready_driver
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   initial begin : monitor
      logic     prev_stall;
      logic     prev_bit;
      logic     prev_last;
      logic     gap;
      exp_bit_t e;
      prev_stall = 1'b0;
      prev_bit   = 1'b0;
      prev_last  = 1'b0;
      gap        = 1'b0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            prev_stall = 1'b0;
            gap        = 1'b0;
         end else begin
            if (gap) begin
               chk("gap_tx_valid", 32'(tx_valid), 32'd0);
               chk("gap_busy", 32'(busy), 32'd0);
               chk("gap_tx_last", 32'(tx_last), 32'd0);
               gap = 1'b0;
            end
            if (prev_stall) begin
               chk("stall_tx_valid", 32'(tx_valid), 32'd1);
               chk("stall_tx_bit", 32'(tx_bit), 32'(prev_bit));
               chk("stall_tx_last", 32'(tx_last), 32'(prev_last));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_bit   = tx_bit;
            prev_last  = tx_last;
            if (tx_valid && tx_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_bit at %0t: got tx_bit=%0b with nothing expected", $time, tx_bit);
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("tx_bit[%0d]", e.idx), 32'(tx_bit), 32'(e.b));
                  chk($sformatf("tx_last[%0d]", e.idx), 32'(tx_last), 32'(e.last));
                  if (e.last) gap = 1'b1;
               end
            end
         end
      end
   end

   task automatic send_word(input logic [WordSize-1:0] w);
      int n = 0;
      while (!in_ready && n < 5000) begin
         tick();
         n++;
      end
      if (n >= 5000) fail_now("send_word_in_ready");
      in_word  = w;
      in_valid = 1'b1;
      model_accept(w);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || tx_valid) && n < 20000) begin
         tick();
         n++;
      end
      if (n >= 20000) fail_now(name);
      tick();
      tick();
   endtask

   task automatic wait_idx(input int idx, input string name);
      int n = 0;
      while (!(exp_q.size() > 0 && exp_q[0].idx == idx) && n < 5000) begin
         tick();
         n++;
      end
      if (n >= 5000) fail_now(name);
   endtask

   task automatic abort_reset(input string name);
      reset = 1'b0;
      #1;
      chk({name, "_tx_valid"}, 32'(tx_valid), 32'd0);
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({name, "_tx_last"}, 32'(tx_last), 32'd0);
      chk({name, "_tx_bit"}, 32'(tx_bit), 32'd0);
      chk({name, "_overflow"}, 32'(overflow), 32'd0);
      exp_q.delete();
      pend_q.delete();
      in_valid = 1'b0;
      tick();
      chk({name, "_tx_valid_next"}, 32'(tx_valid), 32'd0);
      tick();
      reset = 1'b1;
      tick();
   endtask

   // Back-to-back pushes with tx_ready held low from an idle, empty framer.
   // The frame start takes the head word on the edge of push FrameWords+1,
   // so occupancy is (accepted pushes) minus one from then on.
   task automatic burst(input int n);
      int   cnt = 0;
      logic exp_rdy;
      for (int j = 1; j <= n; j++) begin
         exp_rdy = (cnt != FifoDepth);
         chk($sformatf("burst_in_ready[%0d]", j), 32'(in_ready), 32'(exp_rdy));
         in_word  = WordSize'($urandom);
         in_valid = 1'b1;
         if (exp_rdy) model_accept(in_word);
         tick();
         if (exp_rdy) cnt++;
         if (j == FrameWords + 1) cnt--;
      end
      in_valid = 1'b0;
      chk("burst_in_ready_end", 32'(in_ready), 32'(cnt != FifoDepth));
      chk("burst_overflow", 32'(overflow), 32'(n > FifoDepth + 1));
   endtask

   initial begin : stimulus
      int n;
      in_valid = 1'b0;
      in_word  = '0;
      tx_ready = 1'b0;
      reset    = 1'b0;
      #12;
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_bit", 32'(tx_bit), 32'd0);
      chk("rst_tx_last", 32'(tx_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      reset = 1'b1;
      tick();

      // Known pattern under random back-pressure.
      rdy_mode = 2;
      send_word(8'hA5);
      send_word(8'h3C);
      send_word(8'h00);
      send_word(8'hFF);
      drain("drain_pattern");

      // Random words with random arrival gaps.
      for (int i = 0; i < 6 * FrameWords; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         send_word(WordSize'($urandom));
      end
      drain("drain_random");
      chk("random_overflow", 32'(overflow), 32'd0);

      // Fill to full, then push on the word-boundary pop while full.
      rdy_mode = 0;
      tick();
      tick();
      burst(FifoDepth + 1);
      rdy_mode = 1;
      n = 0;
      while (!(tx_ready && exp_q.size() > 0 && exp_q[0].idx == WordSize - 1) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) fail_now("full_pop_wait");
      chk("full_pop_in_ready_before", 32'(in_ready), 32'd0);
      in_word  = WordSize'($urandom);
      in_valid = 1'b1;
      model_accept(in_word);
      tick();
      in_valid = 1'b0;
      chk("full_pop_in_ready_after", 32'(in_ready), 32'd0);
      chk("full_pop_overflow", 32'(overflow), 32'd0);
      rdy_mode = 2;
      while (pend_q.size() != 0) send_word(WordSize'($urandom));
      drain("drain_full_pop");
      chk("full_pop_overflow_end", 32'(overflow), 32'd0);

      // Abort during a data bit, with extra words queued behind the frame.
      for (int i = 0; i < FrameWords + 2; i++) send_word(WordSize'($urandom));
      wait_idx(13, "abort_data_wait");
      abort_reset("abort_data");
`ifdef RSA_REPLY_CRC16_EN
      for (int i = 0; i < FrameWords; i++) send_word(WordSize'($urandom));
      wait_idx(DataBits + 5, "abort_crc_wait");
      abort_reset("abort_crc");
`endif
      for (int i = 0; i < FrameWords; i++) send_word(WordSize'($urandom));
      drain("drain_after_abort");

      // Overflow: one word more than the FIFO can hold while stalled.
      rdy_mode = 0;
      tick();
      tick();
      burst(FifoDepth + 2);
      repeat (5) tick();
      chk("overflow_sticky", 32'(overflow), 32'd1);
      reset = 1'b0;
      #1;
      chk("overflow_cleared", 32'(overflow), 32'd0);
      chk("overflow_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      pend_q.delete();
      tick();
      reset = 1'b1;
      rdy_mode = 2;
      repeat (FrameBits) tick();
      chk("overflow_rst_idle", 32'(tx_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog at %0t: simulation time limit reached", $time);
      $fatal(1);
   end

endmodule
